// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response UART transmit path.
// Holds the frame FSM encoding and the default bit timing for a 100 MHz clock at 115200 baud.
package puf_pkg;

    localparam int RESP_W               = 8;
    localparam int BIT_IDX_W            = $clog2(RESP_W);
    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int CNT_W_DEFAULT        = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/puf_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit period.
module puf_baud_tick
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = (count == LAST);

    // Wrapping at bit_end keeps the count at or below CLKS_PER_BIT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/puf_response_uart_tx.sv
// Captures each new PUF response from the response buffer and sends it as one 8N1 UART frame, LSB first.
// Reports completion with a one-cycle tx_done pulse and flags dropped responses in a sticky overrun bit.
module puf_response_uart_tx
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready_to_read,
    input  logic [RESP_W-1:0] response,
    input  logic              clr_overrun,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic              overrun
);

    // Handshake: a response is offered in the cycle where ready_to_read is high and was low the
    // cycle before, and response is sampled only in that cycle. There is no back-pressure: an offer
    // made while a frame is in flight (including its final stop cycle) is dropped and sets overrun.

    tx_state_t               state;
    tx_state_t               state_next;
    logic                    rtr_q;
    logic                    new_resp;
    logic                    bit_end;
    logic                    last_bit;
    logic [RESP_W-1:0]       shift;
    logic [BIT_IDX_W-1:0]    bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtr_q <= 1'b0;
        end else begin
            rtr_q <= ready_to_read;
        end
    end

    assign new_resp = ready_to_read & ~rtr_q;
    assign last_bit = (bit_idx == BIT_IDX_W'(RESP_W - 1));

    // The counter sits at zero while idle, so START always begins a full bit period.
    puf_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_resp) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_bit) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is decoded from registered state so reset drives the line high without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_resp) begin
                        shift   <= response;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) bit_idx <= '0;
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Setting takes priority over a coincident clear.
            if (new_resp && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_puf_response_uart_tx.sv
// Bench for puf_response_uart_tx: a frame-level model plus UART receive monitor checked every cycle,
// with directed scenarios pinned to hand-computed values and a randomized soak.
module tb_puf_response_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready_to_read;
    logic [7:0] response;
    logic       clr_overrun;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       overrun;

    puf_response_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ready_to_read (ready_to_read),
        .response      (response),
        .clr_overrun   (clr_overrun),
        .tx            (tx),
        .busy          (busy),
        .tx_done       (tx_done),
        .overrun       (overrun)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_log[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level model: a frame is a 10-bit word {stop, data, start} shown for CPB cycles per bit,
    // counted in cycles since capture.
    logic       m_prev;
    logic       m_active;
    logic       m_done;
    logic       m_ovr;
    int         m_k;
    logic [9:0] m_frame;
    logic       m_new;
    logic       m_was;
    logic [7:0] m_exp;
    logic [7:0] m_got;

    function automatic void model_reset();
        m_prev   = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_ovr    = 1'b0;
        m_k      = 0;
        exp_q.delete();
        rx_q.delete();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            m_new  = ready_to_read && !m_prev;
            m_prev = ready_to_read;
            m_was  = m_active;
            m_done = 1'b0;
            if (m_was) begin
                m_k++;
                if (m_k == FRAME) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_exp    = exp_q.pop_front();
                    check("rx_frame_count", rx_q.size(), 1);
                    if (rx_q.size() > 0) begin
                        m_got = rx_q.pop_front();
                        check("rx_byte", m_got, m_exp);
                        rx_log.push_back(m_got);
                    end
                end
            end
            if (m_new && m_was) begin
                m_ovr = 1'b1;
            end else begin
                if (m_new) begin
                    m_active = 1'b1;
                    m_k      = 0;
                    m_frame  = {1'b1, response, 1'b0};
                    exp_q.push_back(response);
                end
                if (clr_overrun) m_ovr = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_tx_done", tx_done, 0);
            check("rst_overrun", overrun, 0);
        end else begin
            check("tx", tx, m_active ? m_frame[m_k / CPB] : 1'b1);
            check("busy", busy, m_active);
            check("tx_done", tx_done, m_done);
            check("overrun", overrun, m_ovr);
        end
    end

    // UART receive monitor: samples the middle of each bit period.
    logic       mon_busy = 1'b0;
    int         mon_cnt;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB == CPB / 2) && (mon_cnt > CPB) && (mon_cnt < 9 * CPB)) begin
                mon_byte[mon_cnt / CPB - 1] = tx;
            end
            if (mon_cnt == 9 * CPB + CPB / 2) begin
                check("stop_bit", tx, 1);
                rx_q.push_back(mon_byte);
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (n < 200) begin
            step();
            n++;
            if (busy) nb++;
            if (tx_done) break;
        end
    endtask

    task automatic offer(input logic [7:0] v);
        response      = v;
        ready_to_read = 1'b1;
        step(2);
        ready_to_read = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int         t1_pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic       txs[1:60];
    int         n, nb, dn, done_at, base;

    initial begin
        rst           = 1'b1;
        ready_to_read = 1'b0;
        response      = 8'h00;
        clr_overrun   = 1'b0;
        step(3);
        rst = 1'b0;
        step(3);

        // Single 0xA5 frame with pinned timing and bit pattern.
        check("t1_idle_tx", tx, 1);
        response      = 8'hA5;
        ready_to_read = 1'b1;
        done_at       = 0;
        nb            = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 3) ready_to_read = 1'b0;
            txs[i] = tx;
            if (busy) nb++;
            if (tx_done && done_at == 0) done_at = i;
        end
        check("t1_latency_tx", txs[1], 0);
        check("t1_last_start", txs[4], 0);
        check("t1_first_data", txs[5], 1);
        for (int b = 0; b < 10; b++) check("t1_bit", txs[b * CPB + 3], t1_pat[b]);
        check("t1_done_cycle", done_at, 41);
        check("t1_busy_cycles", nb, 40);
        check("t1_rx_count", rx_log.size(), 1);
        if (rx_log.size() > 0) check("t1_rx_byte", rx_log[0], 8'hA5);

        // Level held high: exactly one frame.
        base          = rx_log.size();
        response      = 8'h3C;
        ready_to_read = 1'b1;
        dn            = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_done) dn++;
        end
        ready_to_read = 1'b0;
        step(2);
        check("t2_done_count", dn, 1);
        check("t2_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t2_rx_byte", rx_log[base], 8'h3C);
        check("t2_overrun", overrun, 0);

        // Offer during DATA is dropped and flagged.
        base = rx_log.size();
        offer(8'h12);
        step(14);
        offer(8'hFF);
        wait_done(n, nb);
        step(50);
        check("t3_overrun_set", overrun, 1);
        check("t3_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t3_rx_byte", rx_log[base], 8'h12);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("t3_overrun_clr", overrun, 0);
        step(5);

        // Reset during data bit 3 abandons the frame.
        base          = rx_log.size();
        response      = 8'h81;
        ready_to_read = 1'b1;
        step(2);
        ready_to_read = 1'b0;
        step(16);
        rst = 1'b1;
        #1;
        check("t4_rst_tx", tx, 1);
        check("t4_rst_busy", busy, 0);
        step(2);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_done) dn++;
        end
        check("t4_no_done", dn, 0);
        check("t4_no_rx", rx_log.size() - base, 0);
        offer(8'h81);
        wait_done(n, nb);
        check("t4_done_cycle", n + 2, 41);
        step(2);
        check("t4_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t4_rx_byte", rx_log[base], 8'h81);

        // Back-to-back: offer in the tx_done cycle starts the next frame one cycle later.
        offer(8'h55);
        wait_done(n, nb);
        base          = rx_log.size();
        response      = 8'h00;
        ready_to_read = 1'b1;
        step();
        ready_to_read = 1'b0;
        check("t5_start_tx", tx, 0);
        check("t5_start_busy", busy, 1);
        check("t5_no_overrun", overrun, 0);
        wait_done(n, nb);
        check("t5_done_cycle", n, 40);
        step(2);
        check("t5_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t5_rx_byte", rx_log[base], 8'h00);
        check("t5_overrun", overrun, 0);

        // ready_to_read already high as reset releases.
        rst           = 1'b1;
        response      = 8'h5A;
        ready_to_read = 1'b1;
        step(2);
        rst  = 1'b0;
        base = rx_log.size();
        check("t6_idle_tx", tx, 1);
        step();
        check("t6_start_tx", tx, 0);
        check("t6_start_busy", busy, 1);
        wait_done(n, nb);
        check("t6_done_cycle", n, 40);
        ready_to_read = 1'b0;
        step(2);
        check("t6_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t6_rx_byte", rx_log[base], 8'h5A);

        // Randomized soak: offers, overruns, clears and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 15) == 0) ready_to_read = ~ready_to_read;
            response    = 8'($urandom);
            clr_overrun = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 2));
                rst = 1'b0;
            end
        end
        ready_to_read = 1'b0;
        clr_overrun   = 1'b0;
        step(60);
        check("drain_exp_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/puf_response_uart_tx.md
Name: puf_response_uart_tx

Overview:
- Consumer end of the PUF response path: watches the response-collection buffer's ready_to_read, captures the 8-bit response and serialises it over a UART TX line (8N1, LSB first) to the host.
- Sits between the response buffer and the board UART pin.
- Gives the top level a one-cycle done pulse and a sticky overrun flag.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- CNT_W, 10, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- ready_to_read  input  1  level from response buffer; a 0->1 transition means a new response is valid.
- response  input  8  PUF response, valid when ready_to_read rises.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from capture until the end of the stop bit.
- tx_done  output  1  one-cycle pulse after the stop bit completes.
- overrun  output  1  sticky; set when a new response arrives while busy.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: tx=1, busy=0, tx_done=0, overrun=0, state=IDLE, baud counter=0, bit index=0, shift register=0, ready_to_read edge register=0.
- Edge detect: register ready_to_read each cycle; new_resp = ready_to_read & ~rtr_q.
  - A level held high across many cycles produces exactly one capture.
  - ready_to_read already high when rst deasserts: rtr_q resets to 0, so this yields one capture on the first clock after reset.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On new_resp, shift register <= response, busy <= 1, baud counter <= 0, go to START next cycle. Capture latency is 1 cycle: tx falls on the cycle after new_resp.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right by 1 and increment bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then return to IDLE, busy <= 0, and tx_done=1 for exactly that one cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first tx=0 cycle to the tx_done pulse.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and never exceeds CLKS_PER_BIT-1.
- New response while busy (START/DATA/STOP):
  - The response is dropped and overrun <= 1; the current frame is unaffected.
  - A new response in the same cycle as the STOP->IDLE transition also counts as overrun; the block does not chain frames.
- overrun clearing: cleared only by rst or clr_overrun. If clr_overrun and an overrun event coincide, set wins.
- Mid-frame reset: tx returns to 1 immediately (asynchronously), the frame is abandoned, and no tx_done pulse is produced.
- response is sampled only on the capture cycle; later changes do not alter the frame in flight.

Decomposition:
- Shared package puf_pkg holds:
  - the state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - RESP_W=8;
  - the default CLKS_PER_BIT.
- One natural sub-module, puf_baud_tick: parameterised counter with clear input; emits bit_end when count==CLKS_PER_BIT-1.
- Edge detect and FSM stay in the top module.

Test Plan:
- CLKS_PER_BIT=4, response=8'hA5, single ready_to_read rise.
  - tx line: 1-cycle latency, then 0 x4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 x4 cycles.
  - tx_done pulses at cycle 41 after the rise; busy is high for 40 cycles.
- ready_to_read held high for 200 cycles with response=8'h3C -> exactly one frame (0x3C decoded by the bench UART monitor) and one tx_done; overrun stays 0.
- Second rise with response=8'hFF during DATA of a 0x12 frame.
  - 0x12 frame completes intact; no 0xFF frame; overrun=1.
  - clr_overrun pulse returns overrun to 0.
- Assert rst during bit 3 of a 0x81 frame -> tx=1 in the same cycle, busy=0, no tx_done. A fresh rise with 0x81 then transmits a complete, correct frame.
- Back-to-back: second rise one cycle after tx_done with 8'h00 -> second frame starts on the next cycle, no overrun, and the bench decodes 0x00.
- rst deasserted while ready_to_read=1 with response=8'h5A -> one frame 0x5A starts on the first clock after reset.
